// File: rtl/cpu_pkg.sv
// Shared decode definitions: opcode values, op-class bit positions and the
// decoded-entry record passed from decode to execute.
package cpu_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // op[2:0] carries funct3 (or opc[5:3] for jumps/upper-immediates)
  localparam int OP_ALU_BIT = 3;
  localparam int OP_MEM_BIT = 4;  // memory class, or alternate ALU variant
  localparam int OP_HI_BIT  = 5;

  // imm and pc are held at the widest XLEN; consumers take the low XLEN bits
  typedef struct packed {
    logic [5:0]          op;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [XLEN_MAX-1:0] imm;
    logic                use_imm;
    logic                illegal;
    logic [XLEN_MAX-1:0] pc;
  } dec_entry_t;

  function automatic logic [XLEN_MAX-1:0] sext32(input logic [31:0] v);
    return {{(XLEN_MAX-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational instruction decoder: 32-bit instruction word to decoded entry.
module decode_comb
  import cpu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit ZERO_IS_NOP = 1'b1
) (
  input  logic [31:0]     idata,
  input  logic [XLEN-1:0] pc,
  output dec_entry_t      entry
);

  logic [6:0]          opc;
  logic [2:0]          funct3;
  logic                is_shift;
  logic [XLEN_MAX-1:0] imm_i;
  logic [XLEN_MAX-1:0] imm_s;
  logic [XLEN_MAX-1:0] imm_b;
  logic [XLEN_MAX-1:0] imm_j;
  logic [XLEN_MAX-1:0] imm_u;
  logic [XLEN_MAX-1:0] shamt;

  assign opc      = idata[6:0];
  assign funct3   = idata[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_i = sext32({{20{idata[31]}}, idata[31:20]});
  assign imm_s = sext32({{20{idata[31]}}, idata[31:25], idata[11:7]});
  assign imm_b = sext32({{19{idata[31]}}, idata[31], idata[7], idata[30:25], idata[11:8], 1'b0});
  assign imm_j = sext32({{11{idata[31]}}, idata[31], idata[19:12], idata[20], idata[30:21], 1'b0});
  assign imm_u = sext32({idata[31:12], 12'b0});
  assign shamt = (XLEN == 64) ? {58'b0, idata[25:20]} : {59'b0, idata[24:20]};

  always_comb begin
    entry          = '0;
    entry.rs1      = idata[19:15];
    entry.rs2      = idata[24:20];
    entry.rd       = idata[11:7];
    entry.pc[XLEN-1:0] = pc;
    case (opc)
      OPC_OP, OPC_OPIMM: begin
        entry.op[2:0]        = funct3;
        entry.op[OP_ALU_BIT] = 1'b1;
        entry.op[OP_HI_BIT]  = opc[5];
        if (opc == OPC_OP) begin
          entry.op[OP_MEM_BIT] = idata[30];
        end else begin
          entry.op[OP_MEM_BIT] = is_shift & idata[30];
          entry.imm            = is_shift ? shamt : imm_i;
          entry.use_imm        = 1'b1;
        end
      end
      OPC_LOAD, OPC_STORE: begin
        entry.op[2:0]        = funct3;
        entry.op[OP_MEM_BIT] = 1'b1;
        entry.op[OP_HI_BIT]  = opc[5];
        entry.imm            = opc[5] ? imm_s : imm_i;
        entry.use_imm        = 1'b1;
      end
      OPC_BRANCH: begin
        entry.op[2:0]       = funct3;
        entry.op[OP_HI_BIT] = 1'b1;
        entry.imm           = imm_b;
      end
      OPC_JALR: begin
        entry.op[2:0] = opc[5:3];
        entry.imm     = imm_i;
        entry.use_imm = 1'b1;
      end
      OPC_JAL: begin
        entry.op[2:0] = opc[5:3];
        entry.imm     = imm_j;
      end
      OPC_AUIPC, OPC_LUI: begin
        entry.op[2:0] = opc[5:3];
        entry.imm     = imm_u;
      end
      default: begin
        entry.illegal = !(ZERO_IS_NOP && (idata == 32'b0));
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decode_comb followed by a main register and an
// optional skid register so that in_ready comes straight from a flop.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit SKID        = 1'b1,
  parameter bit ZERO_IS_NOP = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_idata,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      op,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic            use_imm,
  output logic            illegal,
  output logic [XLEN-1:0] out_pc
);

  dec_entry_t dec;
  dec_entry_t main_q;
  dec_entry_t skid_q;
  logic       main_valid;
  logic       skid_valid;
  logic       in_ready_q;
  logic       accept;
  logic       main_free;

  decode_comb #(
    .XLEN       (XLEN),
    .ZERO_IS_NOP(ZERO_IS_NOP)
  ) u_decode_comb (
    .idata(in_idata),
    .pc   (in_pc),
    .entry(dec)
  );

  assign in_ready  = SKID ? in_ready_q : (!main_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign main_free = !main_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (SKID) begin
      // in_ready_q is low whenever skid_valid is set, so accept and a
      // pending skid entry never coincide
      if (main_free) begin
        if (skid_valid) begin
          main_q     <= skid_q;
          main_valid <= 1'b1;
          skid_valid <= 1'b0;
          in_ready_q <= 1'b1;
        end else if (accept) begin
          main_q     <= dec;
          main_valid <= 1'b1;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_q     <= dec;
        skid_valid <= 1'b1;
        in_ready_q <= 1'b0;
      end
    end else begin
      if (accept) begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end else if (out_ready) begin
        main_valid <= 1'b0;
      end
    end
  end

  generate
    if (XLEN < XLEN_MAX) begin : g_hi_unused
      logic unused_hi;
      assign unused_hi = ^{main_q.imm[XLEN_MAX-1:XLEN], main_q.pc[XLEN_MAX-1:XLEN]};
    end
  endgenerate

  assign out_valid = main_valid;
  assign op        = main_q.op;
  assign rs1       = main_q.rs1;
  assign rs2       = main_q.rs2;
  assign rd        = main_q.rd;
  assign imm       = main_q.imm[XLEN-1:0];
  assign use_imm   = main_q.use_imm;
  assign illegal   = main_q.illegal;
  assign out_pc    = main_q.pc[XLEN-1:0];

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: 32-bit instance with skid buffer plus a
// 64-bit instance sharing the handshake, checked against hand-decoded values.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_idata;
  logic [31:0] in_pc;
  logic [31:0] in_idata64;
  logic [63:0] in_pc64;

  logic        in_ready, out_valid, use_imm, illegal;
  logic [5:0]  op;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm, out_pc;

  logic        in_ready64, out_valid64, use_imm64, illegal64;
  logic [5:0]  op64;
  logic [4:0]  rs1_64, rs2_64, rd64;
  logic [63:0] imm64, out_pc64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .SKID(1'b1), .ZERO_IS_NOP(1'b1)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_idata(in_idata), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .use_imm(use_imm), .illegal(illegal), .out_pc(out_pc)
  );

  decode_stage #(.XLEN(64), .SKID(1'b1), .ZERO_IS_NOP(1'b1)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_idata(in_idata64), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(out_ready),
    .op(op64), .rs1(rs1_64), .rs2(rs2_64), .rd(rd64), .imm(imm64),
    .use_imm(use_imm64), .illegal(illegal64), .out_pc(out_pc64)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one edge; inputs change and outputs are sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_idata = instr;
    in_pc    = pc;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_idata = '0; in_pc = '0; in_idata64 = '0; in_pc64 = '0;
    step(); step();
    reset = 1'b0;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_op", op, 0);
    check_val("rst_imm", imm, 0);
    check_val("rst_out_pc", out_pc, 0);
    step();
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid_1", out_valid, 0);

    // addi x1,x2,-5
    offer(32'hFFB10093, 32'h100);
    step();
    check_val("addi_valid", out_valid, 1);
    check_val("addi_op", op, 6'b001000);
    check_val("addi_imm", imm, 32'hFFFFFFFB);
    check_val("addi_use_imm", use_imm, 1);
    check_val("addi_rd", rd, 1);
    check_val("addi_rs1", rs1, 2);
    check_val("addi_illegal", illegal, 0);
    check_val("addi_pc", out_pc, 32'h100);

    // sub then beq -8 back to back
    offer(32'h40208033, 32'h104);
    step();
    check_val("sub_op", op, 6'b111000);
    check_val("sub_imm", imm, 0);
    check_val("sub_use_imm", use_imm, 0);
    check_val("sub_in_ready", in_ready, 1);
    offer(32'hFE000CE3, 32'h108);
    step();
    check_val("beq_op", op, 6'b100000);
    check_val("beq_imm", imm, 32'hFFFFFFF8);
    check_val("beq_use_imm", use_imm, 0);
    check_val("beq_in_ready", in_ready, 1);
    check_val("beq_pc", out_pc, 32'h108);

    // srai x1,x2,3 and sw x5,-4(x2)
    offer(32'h40315093, 32'h10C);
    step();
    check_val("srai_op", op, 6'b011101);
    check_val("srai_imm", imm, 3);
    check_val("srai_use_imm", use_imm, 1);
    offer(32'hFE512E23, 32'h110);
    step();
    check_val("sw_op", op, 6'b110010);
    check_val("sw_imm", imm, 32'hFFFFFFFC);
    check_val("sw_rs2", rs2, 5);
    in_valid = 1'b0;
    step();
    check_val("idle_out_valid", out_valid, 0);

    // stall: three offered, two accepted, then in-order drain
    out_ready = 1'b0;
    offer(32'h00500193, 32'h200);
    step();
    check_val("stall_a_valid", out_valid, 1);
    check_val("stall_a_in_ready", in_ready, 1);
    offer(32'h00A00213, 32'h204);
    step();
    check_val("stall_b_in_ready", in_ready, 0);
    check_val("stall_b_head_pc", out_pc, 32'h200);
    offer(32'h00F00293, 32'h208);
    step();
    check_val("stall_c_in_ready", in_ready, 0);
    check_val("stall_c_head_pc", out_pc, 32'h200);
    check_val("stall_c_head_imm", imm, 5);
    out_ready = 1'b1;
    step();
    check_val("drain_b_pc", out_pc, 32'h204);
    check_val("drain_b_imm", imm, 10);
    check_val("drain_b_rd", rd, 4);
    check_val("drain_b_in_ready", in_ready, 1);
    step();
    check_val("drain_c_pc", out_pc, 32'h208);
    check_val("drain_c_imm", imm, 15);
    check_val("drain_c_valid", out_valid, 1);
    in_valid = 1'b0;
    step();
    check_val("drain_empty", out_valid, 0);

    // flush with both entries held and a new input offered
    out_ready = 1'b0;
    offer(32'h00100313, 32'h300);
    step();
    offer(32'h00200393, 32'h304);
    step();
    check_val("pre_flush_in_ready", in_ready, 0);
    offer(32'h00300413, 32'h308);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("flush_out_valid", out_valid, 0);
    check_val("flush_in_ready", in_ready, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check_val("post_flush_valid", out_valid, 0);

    // illegal opcodes and the all-zero nop
    offer(32'h0000007F, 32'h400);
    step();
    check_val("ill7f_valid", out_valid, 1);
    check_val("ill7f_illegal", illegal, 1);
    check_val("ill7f_op", op, 0);
    check_val("ill7f_use_imm", use_imm, 0);
    offer(32'h00000000, 32'h404);
    step();
    check_val("zero_valid", out_valid, 1);
    check_val("zero_illegal", illegal, 0);
    check_val("zero_op", op, 0);
    offer(32'h00500190, 32'h408);
    step();
    check_val("ill_lo_illegal", illegal, 1);
    check_val("ill_lo_imm", imm, 0);
    check_val("ill_lo_rd", rd, 3);
    in_valid = 1'b0;
    step();

    // XLEN=64: lui, jal -4, slli with 6-bit shamt
    in_valid = 1'b1;
    in_idata64 = 32'h800002B7; in_pc64 = 64'h1000;
    step();
    check_val("lui64_imm", imm64, 64'hFFFFFFFF80000000);
    check_val("lui64_op", op64, 6'b000110);
    check_val("lui64_rd", rd64, 5);
    in_idata64 = 32'hFFDFF0EF; in_pc64 = 64'h1004;
    step();
    check_val("jal64_imm", imm64, 64'hFFFFFFFFFFFFFFFC);
    check_val("jal64_op", op64, 6'b000101);
    check_val("jal64_pc", out_pc64, 64'h1004);
    in_idata64 = 32'h02111093; in_pc64 = 64'h1008;
    step();
    check_val("slli64_imm", imm64, 33);
    check_val("slli64_op", op64, 6'b001001);
    in_valid = 1'b0;
    step();
    check_val("end64_valid", out_valid64, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, parametrised instruction-decode pipeline stage that replaces the purely combinational decoder between fetch and execute. Accepts one 32-bit instruction per cycle over a valid/ready handshake and emits the team's 6-bit op encoding, register addresses, an XLEN-wide immediate and an illegal-instruction flag. Includes a 2-entry skid buffer so `in_ready` is registered. A flush port discards in-flight instructions on branch redirect.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; immediates sign-extend to XLEN.
SKID, 1, 1 = 2-entry skid buffer with registered `in_ready`; 0 = single register with `in_ready = !out_valid || out_ready`.
ZERO_IS_NOP, 1, 1 = all-zero instruction decodes to op=0 and illegal=0; 0 = all-zero instruction is illegal.

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  discard all held entries this cycle
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage can accept
in_idata  in  32  instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  decoded entry available
out_ready  in  1  execute accepts
op  out  6  operation encoding
rs1  out  5  source 1 address, idata[19:15]
rs2  out  5  source 2 address, idata[24:20]
rd  out  5  destination address, idata[11:7]
imm  out  XLEN  immediate
use_imm  out  1  ALU operand 2 is imm, not rf value
illegal  out  1  unsupported encoding
out_pc  out  XLEN  pc of decoded entry

Behaviour:
- Reset: out_valid=0; op, rs1, rs2, rd, imm, use_imm, illegal, out_pc=0; skid empty; in_ready=1 on the first cycle after reset deasserts.
- Transfer: input on in_valid && in_ready; output on out_valid && out_ready. Latency is 1 cycle (accepted at edge N, visible after edge N).
- Ordering is strict FIFO. No loss or duplication. Output fields hold stable while out_valid && !out_ready.
- Skid (SKID=1): main register plus skid register.
  - If an input is accepted while the main register is stalled, it goes to the skid register.
  - in_ready = !skid_valid, registered.
  - When the main register drains, the skid entry moves to main in the same edge.
  - Simultaneous accept and drain with skid empty: the new entry goes directly to main.
- Flush: at the edge where flush=1, main and skid are invalidated and any same-cycle input is dropped.
  - out_valid=0 and in_ready=1 on the next cycle.
  - flush has priority over every handshake. Reset has priority over flush.
- Opcode field: opc = idata[6:0]. Any opc not listed below, or opc[1:0] != 11, gives illegal=1, op=0, use_imm=0, imm=0. rs/rd still pass through.
- Op encoding:
  - ALU, opc 0110011 or 0010011: op[3]=1, op[5]=opc[5], op[2:0]=funct3.
    - op[4]=funct7[5] for reg-reg, and for immediate shifts (funct3 = 001 or 101).
    - op[4]=0 otherwise.
  - Load 0000011 / store 0100011: op[4:3]=10, op[5]=opc[5], op[2:0]=funct3.
  - Branch 1100011: op[5:3]=100, op[2:0]=funct3.
  - JALR 1100111, JAL 1101111, AUIPC 0010111, LUI 0110111: op[5:3]=000, op[2:0]=opc[5:3], giving 100, 101, 010 and 110 respectively.
- Immediates, sign-extended to XLEN:
  - I-type for ALU-imm, load and JALR.
  - Shift-immediate: zero-extended shamt, idata[24:20] when XLEN=32, idata[25:20] when XLEN=64.
  - S-type for store.
  - B-type for branch: imm[12|10:5|4:1|11], bit0=0.
  - J-type for JAL: imm[20|10:1|11|19:12], bit0=0.
  - U-type for LUI/AUIPC: {idata[31:12], 12'b0}, sign-extended.
  - Reg-reg: imm=0.
- use_imm=1 for ALU-imm, load, store and JALR; 0 otherwise.
- illegal never suppresses out_valid; execute raises the trap.

Decomposition:
- Shared package `cpu_pkg`:
  - opcode localparams: OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_AUIPC, OPC_LUI;
  - op-class bit positions;
  - decoded-entry struct {op, rs1, rs2, rd, imm, use_imm, illegal, pc}.
- One sub-module, `decode_comb`: purely combinational idata -> decoded entry, parametrised by XLEN and ZERO_IS_NOP.
- decode_stage wraps decode_comb with the main/skid registers and the handshake.

Test Plan:
- Reset, then stream `addi x1,x2,-5` (0xFFB10093), out_ready=1 -> one cycle later out_valid=1, op=001000, imm=0xFFFFFFFB, use_imm=1, rd=1, rs1=2.
- Back-to-back `sub` (0x40208033) then `beq` with offset -8 -> first entry op=111000; second op=100000, imm=0xFFFFFFF8, use_imm=0; in_ready stays 1.
- Hold out_ready=0 with 3 instructions offered (SKID=1) -> two accepted and in_ready=0 after the second; the third is held. Releasing out_ready gives in-order delivery and no loss.
- Assert flush while both entries are held and in_valid=1 -> next cycle out_valid=0, in_ready=1; the dropped instructions never appear.
- Opcode 0x0000007F and idata=0 with ZERO_IS_NOP=1 -> first gives illegal=1, op=0; second gives illegal=0, op=0, out_valid=1.
- XLEN=64, `lui x5,0x80000` (0x800002B7) -> imm=0xFFFFFFFF80000000, op=000110; `jal` with offset -4 -> imm=0xFFFF_FFFF_FFFF_FFFC.
